// File: rtl/mcp_rx_sorter.sv
// rtl/mcp_rx_sorter.sv - UART-framed daisy-chain receiver with chip-ID sorting, stats counters and packet FIFO
module mcp_rx_sorter #(
    parameter int WIDTH      = 54,
    parameter int CHIP_ID_W  = 8,
    parameter int NUM_CHIPS  = 3,
    parameter int IDX_W      = 2,
    parameter int CLKDIV     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_BITS  = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                           clk2x,
    input  logic                           reset,
    input  logic                           miso,
    input  logic [NUM_CHIPS*CHIP_ID_W-1:0] chip_id_table,
    input  logic                           clear_counts,
    input  logic                           pkt_ready,
    output logic                           pkt_valid,
    output logic [WIDTH-1:0]               pkt_data,
    output logic [IDX_W-1:0]               pkt_chip_idx,
    output logic                           fifo_full,
    output logic [NUM_CHIPS*COUNT_W-1:0]   hit_counts,
    output logic [COUNT_W-1:0]             unknown_count,
    output logic [COUNT_W-1:0]             parity_err_count,
    output logic [COUNT_W-1:0]             frame_err_count,
    output logic [COUNT_W-1:0]             overflow_count
);
    localparam int PH_W  = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int ENT_W = WIDTH + IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

    logic                 r_sync1, r_sync2;
    state_t               r_state, w_state_nxt;
    logic [PH_W-1:0]      r_phase, w_phase_nxt;
    logic [BIT_W-1:0]     r_bit, w_bit_nxt;
    logic [WIDTH-1:0]     r_shift, w_shift_nxt;
    logic                 w_stop_ok, w_frame_err;
    logic                 r_cls_valid;
    logic [WIDTH-1:0]     r_cls_data;
    logic                 w_rx;

    assign w_rx = r_sync2;

    always_ff @(posedge clk2x) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_cls_valid <= 1'b0;
            r_cls_data  <= '0;
        end else begin
            r_sync1     <= miso;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_cls_valid <= w_stop_ok;
            if (w_stop_ok)
                r_cls_data <= r_shift;
        end
    end

    // Bits arrive LSB first, so shifting in at the MSB leaves bit 0 at position 0.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + PH_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (!w_rx)
                    w_state_nxt = S_START;
            end
            S_START: begin
                if (r_phase == PH_W'(CLKDIV/2 - 1)) begin
                    w_phase_nxt = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_phase == PH_W'(CLKDIV - 1)) begin
                    w_phase_nxt = '0;
                    w_shift_nxt = {w_rx, r_shift[WIDTH-1:1]};
                    if (r_bit == BIT_W'(WIDTH - 1))
                        w_state_nxt = S_STOP;
                    else
                        w_bit_nxt = r_bit + BIT_W'(1);
                end
            end
            S_STOP: begin
                if (r_phase == PH_W'(CLKDIV - 1)) begin
                    w_phase_nxt = '0;
                    if (w_rx) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_phase_nxt = '0;
                if (w_rx)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic                 w_match;
    logic [IDX_W-1:0]     w_idx;
    logic [CHIP_ID_W-1:0] w_id;
    logic                 w_parity_ok, w_do_hit, w_do_unk, w_do_par;

    assign w_id        = r_cls_data[CHIP_ID_W+1:2];
    assign w_parity_ok = ^r_cls_data;

    // Descending scan so the lowest matching table entry wins.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int k = NUM_CHIPS - 1; k >= 0; k--) begin
            if (w_id == chip_id_table[k*CHIP_ID_W +: CHIP_ID_W]) begin
                w_match = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

    assign w_do_par = r_cls_valid & ~w_parity_ok;
    assign w_do_unk = r_cls_valid &  w_parity_ok & ~w_match;
    assign w_do_hit = r_cls_valid &  w_parity_ok &  w_match;

    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0] r_wptr, r_rptr;
    logic [FIFO_BITS:0]   r_count;
    logic                 w_pop, w_wr, w_overflow;
    logic [ENT_W-1:0]     w_head;

    assign pkt_valid  = (r_count != '0);
    assign fifo_full  = (r_count == (FIFO_BITS+1)'(FIFO_DEPTH));
    assign w_pop      = pkt_valid & pkt_ready;
    assign w_wr       = w_do_hit & (~fifo_full | w_pop);
    assign w_overflow = w_do_hit & fifo_full & ~w_pop;
    assign w_head     = r_mem[r_rptr];
    assign pkt_data     = pkt_valid ? w_head[ENT_W-1:IDX_W] : '0;
    assign pkt_chip_idx = pkt_valid ? w_head[IDX_W-1:0]     : '0;

    always_ff @(posedge clk2x) begin
        if (w_wr)
            r_mem[r_wptr] <= {r_cls_data, w_idx};
    end

    always_ff @(posedge clk2x) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + FIFO_BITS'(1);
            if (w_pop)
                r_rptr <= r_rptr + FIFO_BITS'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (FIFO_BITS+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    logic [COUNT_W-1:0] r_hits [NUM_CHIPS];
    logic [COUNT_W-1:0] r_unk, r_par, r_frm, r_ovf;

    always_ff @(posedge clk2x) begin
        if (reset || clear_counts) begin
            for (int k = 0; k < NUM_CHIPS; k++)
                r_hits[k] <= '0;
            r_unk <= '0;
            r_par <= '0;
            r_frm <= '0;
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_CHIPS; k++)
                if (w_do_hit && (w_idx == IDX_W'(k)))
                    r_hits[k] <= sat_inc(r_hits[k]);
            if (w_do_unk)    r_unk <= sat_inc(r_unk);
            if (w_do_par)    r_par <= sat_inc(r_par);
            if (w_frame_err) r_frm <= sat_inc(r_frm);
            if (w_overflow)  r_ovf <= sat_inc(r_ovf);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CHIPS; g++) begin : g_hits
            assign hit_counts[g*COUNT_W +: COUNT_W] = r_hits[g];
        end
    endgenerate

    assign unknown_count    = r_unk;
    assign parity_err_count = r_par;
    assign frame_err_count  = r_frm;
    assign overflow_count   = r_ovf;
endmodule

// File: tb/tb_mcp_rx_sorter.sv
// tb/tb_mcp_rx_sorter.sv - self-checking bench for mcp_rx_sorter
module tb_mcp_rx_sorter;
    localparam int W      = 54;
    localparam int NC     = 3;
    localparam int CW     = 16;
    localparam int DEPTH  = 16;
    localparam int CLKDIV = 2;

    logic clk2x = 1'b0;
    logic reset = 1'b1;
    logic miso = 1'b1;
    logic clear_counts = 1'b0;
    logic pkt_ready = 1'b0;
    logic [NC*8-1:0] chip_id_table = {8'd15, 8'd1, 8'd4};

    logic          pkt_valid, fifo_full;
    logic [W-1:0]  pkt_data;
    logic [1:0]    pkt_chip_idx;
    logic [NC*CW-1:0] hit_counts;
    logic [CW-1:0] unknown_count, parity_err_count, frame_err_count, overflow_count;

    logic          s_valid, s_full;
    logic [W-1:0]  s_data;
    logic [1:0]    s_idx;
    logic [NC*2-1:0] s_hits;
    logic [1:0]    s_unk, s_par, s_frm, s_ovf;

    mcp_rx_sorter dut (
        .clk2x(clk2x), .reset(reset), .miso(miso), .chip_id_table(chip_id_table),
        .clear_counts(clear_counts), .pkt_ready(pkt_ready), .pkt_valid(pkt_valid),
        .pkt_data(pkt_data), .pkt_chip_idx(pkt_chip_idx), .fifo_full(fifo_full),
        .hit_counts(hit_counts), .unknown_count(unknown_count),
        .parity_err_count(parity_err_count), .frame_err_count(frame_err_count),
        .overflow_count(overflow_count)
    );

    mcp_rx_sorter #(.COUNT_W(2)) u_sat (
        .clk2x(clk2x), .reset(reset), .miso(miso), .chip_id_table(chip_id_table),
        .clear_counts(clear_counts), .pkt_ready(pkt_ready), .pkt_valid(s_valid),
        .pkt_data(s_data), .pkt_chip_idx(s_idx), .fifo_full(s_full),
        .hit_counts(s_hits), .unknown_count(s_unk),
        .parity_err_count(s_par), .frame_err_count(s_frm),
        .overflow_count(s_ovf)
    );

    always #5 clk2x = ~clk2x;

    typedef struct { logic [W-1:0] d; int idx; } ent_t;
    ent_t mq[$];
    int m_hit[NC];
    int m_unk, m_par, m_frm, m_ovf;
    int tbl_ids[NC] = '{4, 1, 15};
    int checks = 0, failures = 0, pop_cnt = 0;
    bit rnd_en = 1'b0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NC; k++) m_hit[k] = 0;
        m_unk = 0; m_par = 0; m_frm = 0; m_ovf = 0;
    endtask

    task automatic model_apply(input logic [W-1:0] p, input bit stop_ok);
        int k;
        logic [7:0] id;
        k = -1;
        id = p[9:2];
        if (!stop_ok) m_frm = sat(m_frm);
        else if (!(^p)) m_par = sat(m_par);
        else begin
            for (int i = NC - 1; i >= 0; i--) if (id == tbl_ids[i][7:0]) k = i;
            if (k < 0) m_unk = sat(m_unk);
            else begin
                m_hit[k] = sat(m_hit[k]);
                if (mq.size() < DEPTH) mq.push_back('{p, k});
                else m_ovf = sat(m_ovf);
            end
        end
    endtask

    function automatic logic [W-1:0] make_pkt(input logic [7:0] id, input bit good);
        logic [W-1:0] p;
        p = {$urandom, $urandom};
        p[9:2] = id;
        if ((^p) != good) p[0] = ~p[0];
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk2x);
            #1;
            if (rnd_en) pkt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_bit(input logic b);
        miso = b;
        tick(CLKDIV);
    endtask

    task automatic send_pkt(input logic [W-1:0] p, input bit stop_ok, input bit upd);
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(p[i]);
        drive_bit(stop_ok);
        if (upd) model_apply(p, stop_ok);
    endtask

    task automatic check_counters(input string n);
        for (int k = 0; k < NC; k++)
            chk($sformatf("%s_hit%0d", n, k), 64'(hit_counts[k*CW +: CW]), 64'(m_hit[k]));
        chk({n, "_unknown"}, 64'(unknown_count), 64'(m_unk));
        chk({n, "_parity"}, 64'(parity_err_count), 64'(m_par));
        chk({n, "_frame"}, 64'(frame_err_count), 64'(m_frm));
        chk({n, "_overflow"}, 64'(overflow_count), 64'(m_ovf));
    endtask

    task automatic drain(input string n);
        pkt_ready = 1'b1;
        for (int i = 0; i < 200 && pkt_valid; i++) tick(1);
        pkt_ready = 1'b0;
        chk({n, "_drained"}, 64'(pkt_valid), 64'd0);
        chk({n, "_model_empty"}, 64'(mq.size()), 64'd0);
    endtask

    always @(negedge clk2x) begin
        if (!reset && pkt_valid) begin
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fifo_head actual=%0h required=no_entry", pkt_data);
            end else begin
                chk("fifo_data", 64'(pkt_data), 64'(mq[0].d));
                chk("fifo_idx", 64'(pkt_chip_idx), 64'(mq[0].idx));
            end
        end
    end

    always @(posedge clk2x) begin
        if (!reset && pkt_valid && pkt_ready) begin
            if (mq.size() > 0) mq.delete(0);
            pop_cnt++;
        end
    end

    typedef struct { logic [7:0] id; bit good; bit stop_ok; int cls; int idx; } vec_t;
    localparam int C_HIT = 0, C_UNK = 1, C_PAR = 2, C_FRM = 3;

    initial begin
        vec_t vt[8];
        int t_hit[NC];
        int t_unk, t_par, t_frm;
        logic [W-1:0] p;

        vt[0] = '{8'd4,  1'b0, 1'b1, C_PAR, 0};
        vt[1] = '{8'd7,  1'b1, 1'b1, C_UNK, 0};
        vt[2] = '{8'd1,  1'b1, 1'b0, C_FRM, 0};
        vt[3] = '{8'd1,  1'b1, 1'b1, C_HIT, 1};
        vt[4] = '{8'd4,  1'b1, 1'b1, C_HIT, 0};
        vt[5] = '{8'd15, 1'b1, 1'b1, C_HIT, 2};
        vt[6] = '{8'd0,  1'b1, 1'b1, C_UNK, 0};
        vt[7] = '{8'd15, 1'b0, 1'b1, C_PAR, 0};
        model_clear();

        repeat (3) @(posedge clk2x);
        #1;
        chk("reset_valid", 64'(pkt_valid), 64'd0);
        chk("reset_full", 64'(fifo_full), 64'd0);
        chk("reset_data", 64'(pkt_data), 64'd0);
        chk("reset_idx", 64'(pkt_chip_idx), 64'd0);
        check_counters("reset");
        reset = 1'b0;
        tick(4);

        p = make_pkt(8'd15, 1'b1);
        send_pkt(p, 1'b1, 1'b1);
        tick(2);
        chk("valid_before_write", 64'(pkt_valid), 64'd0);
        tick(1);
        chk("valid_latency", 64'(pkt_valid), 64'd1);
        chk("first_idx", 64'(pkt_chip_idx), 64'd2);
        chk("first_data", 64'(pkt_data), 64'(p));
        check_counters("first");

        for (int k = 0; k < NC; k++) t_hit[k] = 0;
        t_hit[2] = 1; t_unk = 0; t_par = 0; t_frm = 0;
        for (int v = 0; v < 8; v++) begin
            p = make_pkt(vt[v].id, vt[v].good);
            send_pkt(p, vt[v].stop_ok, 1'b1);
            if (!vt[v].stop_ok) begin
                miso = 1'b0;
                tick(20);
                miso = 1'b1;
            end
            tick(4);
            case (vt[v].cls)
                C_HIT: t_hit[vt[v].idx]++;
                C_UNK: t_unk++;
                C_PAR: t_par++;
                default: t_frm++;
            endcase
            for (int k = 0; k < NC; k++)
                chk($sformatf("vec%0d_hit%0d", v, k), 64'(hit_counts[k*CW +: CW]), 64'(t_hit[k]));
            chk($sformatf("vec%0d_unknown", v), 64'(unknown_count), 64'(t_unk));
            chk($sformatf("vec%0d_parity", v), 64'(parity_err_count), 64'(t_par));
            chk($sformatf("vec%0d_frame", v), 64'(frame_err_count), 64'(t_frm));
        end
        drain("table");

        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        model_clear();
        check_counters("cleared");
        for (int i = 0; i < 16; i++) send_pkt(make_pkt(8'd4, 1'b1), 1'b1, 1'b1);
        tick(4);
        chk("fifo_full_16", 64'(fifo_full), 64'd1);
        p = make_pkt(8'd4, 1'b1);
        send_pkt(p, 1'b1, 1'b0);
        tick(2);
        pkt_ready = 1'b1;
        tick(1);
        pkt_ready = 1'b0;
        model_apply(p, 1'b1);
        tick(2);
        chk("full_pop_write_ovf", 64'(overflow_count), 64'd0);
        chk("full_pop_write_full", 64'(fifo_full), 64'd1);
        for (int i = 0; i < 2; i++) send_pkt(make_pkt(8'd4, 1'b1), 1'b1, 1'b1);
        tick(4);
        chk("overflow_count", 64'(overflow_count), 64'd2);
        chk("overflow_hit0", 64'(hit_counts[CW-1:0]), 64'd19);
        chk("sat_hit0", 64'(s_hits[1:0]), 64'd3);
        chk("sat_overflow", 64'(s_ovf), 64'd2);
        check_counters("overflow");
        pop_cnt = 0;
        drain("overflow");
        chk("overflow_pops", 64'(pop_cnt), 64'd16);
        chk("not_full_after_drain", 64'(fifo_full), 64'd0);

        miso = 1'b0;
        tick(1);
        miso = 1'b1;
        tick(10);
        chk("glitch_valid", 64'(pkt_valid), 64'd0);
        check_counters("glitch");

        send_pkt(make_pkt(8'd1, 1'b1), 1'b1, 1'b1);
        tick(4);
        chk("prereset_valid", 64'(pkt_valid), 64'd1);
        p = make_pkt(8'd4, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 30; i++) drive_bit(p[i]);
        miso = p[30];
        tick(1);
        reset = 1'b1;
        miso = 1'b1;
        mq.delete();
        model_clear();
        tick(3);
        chk("midreset_valid", 64'(pkt_valid), 64'd0);
        chk("midreset_full", 64'(fifo_full), 64'd0);
        chk("midreset_data", 64'(pkt_data), 64'd0);
        check_counters("midreset");
        reset = 1'b0;
        tick(4);
        send_pkt(make_pkt(8'd15, 1'b1), 1'b1, 1'b1);
        tick(4);
        chk("postreset_valid", 64'(pkt_valid), 64'd1);
        chk("postreset_idx", 64'(pkt_chip_idx), 64'd2);
        check_counters("postreset");
        drain("postreset");

        p = make_pkt(8'd4, 1'b1);
        send_pkt(p, 1'b1, 1'b0);
        tick(2);
        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        model_apply(p, 1'b1);
        model_clear();
        chk("clear_vs_cls_valid", 64'(pkt_valid), 64'd1);
        chk("clear_vs_cls_hit0", 64'(hit_counts[CW-1:0]), 64'd0);
        check_counters("clear_vs_cls");
        drain("clear_vs_cls");

        rnd_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] id;
            bit good, stop_ok;
            case ($urandom_range(0, 4))
                0: id = 8'd4;
                1: id = 8'd1;
                2: id = 8'd15;
                3: id = 8'd7;
                default: id = 8'($urandom);
            endcase
            good = ($urandom_range(0, 9) < 8);
            stop_ok = ($urandom_range(0, 9) != 0);
            send_pkt(make_pkt(id, good), stop_ok, 1'b1);
            if (!stop_ok) begin
                miso = 1'b0;
                tick(3);
                miso = 1'b1;
            end
            tick(4);
            check_counters($sformatf("rnd%0d", n));
        end
        rnd_en = 1'b0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mcp_rx_sorter.md
# mcp_rx_sorter

Synthesizable MCP-side receiver for the return leg of an N-chip LArPix daisy chain. It deserialises UART-framed WIDTH-bit packets arriving on the last chip's miso and checks odd parity and framing. Each good packet is classified by chip ID against a programmable table of NUM_CHIPS IDs, counted, and buffered in a FIFO with a valid/ready read port. It sits between the chain's miso output and MCP readout logic, and generalises the fixed three-chip, single-stream arrangement to any chain length, with error accounting and backpressure.

## Interface
Parameters:
- WIDTH, 54, packet payload bits excluding start/stop bits; LSB first on the line
- CHIP_ID_W, 8, chip ID field width, located at packet bits [CHIP_ID_W+1:2]
- NUM_CHIPS, 3, number of chips in the chain (1..16)
- IDX_W, 2, bits for chip index; must satisfy 2^IDX_W ≥ NUM_CHIPS
- CLKDIV, 2, clk2x cycles per serial bit (≥2)
- FIFO_DEPTH, 16, packet FIFO entries (power of 2)
- FIFO_BITS, 4, log2(FIFO_DEPTH)
- COUNT_W, 16, width of every statistics counter

Ports:
- clk2x  in  1  sole clock; every flop is rising-edge
- reset  in  1  synchronous, active-high reset
- miso  in  1  serial line from last chip; idles high; asynchronous, 2-flop synchronised inside
- chip_id_table  in  NUM_CHIPS*CHIP_ID_W  expected IDs; entry k occupies [k*CHIP_ID_W +: CHIP_ID_W]
- clear_counts  in  1  one-cycle pulse; zeroes all counters
- pkt_ready  in  1  consumer accepts head of FIFO
- pkt_valid  out  1  FIFO non-empty
- pkt_data  out  WIDTH  head packet
- pkt_chip_idx  out  IDX_W  table index of head packet
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- hit_counts  out  NUM_CHIPS*COUNT_W  per-chip good-packet counts; chip k at [k*COUNT_W +: COUNT_W]
- unknown_count  out  COUNT_W  good-parity packets with no ID match
- parity_err_count  out  COUNT_W  packets failing odd parity
- frame_err_count  out  COUNT_W  packets whose stop bit sampled low
- overflow_count  out  COUNT_W  matched packets dropped because FIFO full

## Operation
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Bit counter 0..WIDTH-1; phase counter 0..CLKDIV-1.
- IDLE: synchronised miso low → START, phase cleared.
- START: after CLKDIV/2 cycles (integer), resample. High → IDLE (glitch, no count). Low → DATA.
- DATA: sample every CLKDIV cycles into shift register bit[n], n = 0..WIDTH-1; after bit WIDTH-1 → STOP.
- STOP: sample CLKDIV cycles later. High → classify, → IDLE. Low → frame_err_count++, packet discarded, → WAIT_IDLE.
- WAIT_IDLE: remain until synchronised miso high, → IDLE.
- Classification (registered, one cycle after stop sample), in priority order:
  - XOR of all WIDTH bits = 0 → parity error; parity_err_count++; discarded.
  - ID matches no table entry → unknown_count++; discarded.
  - ID matches one or more entries → lowest matching index k; hit_counts[k]++. FIFO not full → write {packet, k}. FIFO full → overflow_count++, packet dropped; hit_counts[k] still increments.
- FIFO: first-word-fall-through. pkt_data/pkt_chip_idx are valid whenever pkt_valid = 1. A pop occurs when pkt_valid & pkt_ready.
- Simultaneous write and pop when full: both succeed, and the write is not counted as an overflow. Simultaneous write and pop when holding one entry: pkt_valid stays high and the next entry appears.
- Counters saturate at 2^COUNT_W-1. clear_counts has priority over a same-cycle increment; the increment is lost.
- reset mid-packet: FSM → IDLE. The partial packet is discarded and no counter moves. The FIFO is emptied.

## Timing
- Reset values: pkt_valid = 0, fifo_full = 0, all counters = 0. pkt_data and pkt_chip_idx read 0 while empty. FSM = IDLE. Synchroniser flops = 1.
- Synchroniser latency is 2 cycles. Cycle T is the first cycle synchronised miso is low in IDLE.
- Bit n is sampled at T + CLKDIV/2 + (n+1)*CLKDIV. The stop bit is sampled at S = T + CLKDIV/2 + (WIDTH+1)*CLKDIV.
- Classification, counter update and FIFO write occur at S+1. pkt_valid rises at S+2 if the FIFO was empty.
- FSM re-arms at S+1. A start bit immediately following a stop bit is received correctly.
- Pop takes effect on the clock edge where pkt_valid & pkt_ready. The next entry or pkt_valid = 0 is visible the cycle after.
- fifo_full is asserted the cycle after the write that fills the FIFO.

## Test plan
- CLKDIV = 2, table {4,1,15}; send a good-parity packet with ID 15 → pkt_valid at S+2, pkt_chip_idx = 2, hit_counts[2] = 1, all other counters 0.
- Packet with ID 4 and one bit flipped to even parity → parity_err_count = 1, FIFO empty. Then a packet with ID 7 and good parity → unknown_count = 1, FIFO empty.
- Stop bit driven low for one packet, line held low 20 cycles, then a good ID-1 packet → frame_err_count = 1, then hit_counts[1] = 1 and a valid entry with idx 1.
- pkt_ready = 0; send 18 good ID-4 packets with FIFO_DEPTH = 16 → fifo_full = 1, overflow_count = 2, hit_counts[0] = 18. Drain → 16 packets in send order.
- 1-cycle low glitch on miso while idle → no counter change and no FIFO write. Assert reset at DATA bit 30 → all outputs at reset values, and the next full packet is received correctly.
- Preload hit_counts[0] = 0xFFFF, then send one ID-4 packet → count stays 0xFFFF. clear_counts pulsed in the same cycle as a classification → all counters read 0.
